// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI burst master: channel FSM encoding,
// AXI field encodings and the AxSIZE helper.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5
    } chan_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE encodes bytes-per-beat as log2; the loop keeps it constant-foldable.
    function automatic logic [2:0] axi_size_from_width(input int data_w);
        logic [2:0] sz;
        sz = '0;
        for (int i = 0; i < 8; i++) begin
            if ((data_w / 8) == (1 << i)) sz = 3'(i);
        end
        return sz;
    endfunction

endpackage

// File: rtl/axi_master_burst_chan.sv
// One independent AXI4 master channel: a single fixed-length INCR write or read burst at a time.
// Read data/done are registered (1 cycle); writes stall on AWREADY/WREADY, BREADY/RREADY only in the response/data phases.
module axi_master_burst_chan
    import axi_master_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 34,
    parameter int ID_W      = 6,
    parameter int BURST_LEN = 16
) (
    input  logic                AXI_ACLK,
    input  logic                rst,

    input  logic                wr_req,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_beat_ack,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                wr_done,
    output logic                rd_done,
    output logic                wr_err,
    output logic                rd_err,

    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam logic [4:0] LAST_IDX = 5'(BURST_LEN - 1);
    localparam logic [7:0] AX_LEN   = 8'(BURST_LEN - 1);
    localparam logic [2:0] AX_SIZE  = axi_size_from_width(DATA_W);

    chan_state_t        state;
    logic [ADDR_W-1:0]  addr_q;
    logic [4:0]         beat_cnt;
    logic               rd_err_acc;

    always_ff @(posedge AXI_ACLK or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            beat_cnt   <= '0;
            rd_err_acc <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wr_done    <= 1'b0;
            rd_done    <= 1'b0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        state    <= ST_WR_ADDR;
                        addr_q   <= wr_addr;
                        beat_cnt <= '0;
                    end else if (rd_req) begin
                        state      <= ST_RD_ADDR;
                        addr_q     <= rd_addr;
                        beat_cnt   <= '0;
                        rd_err_acc <= 1'b0;
                    end
                end
                ST_WR_ADDR: begin
                    if (AWREADY) state <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    if (WREADY) begin
                        if (beat_cnt == LAST_IDX) begin
                            state    <= ST_WR_RESP;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (BVALID) begin
                        wr_done <= 1'b1;
                        wr_err  <= (BRESP != AXI_RESP_OKAY);
                        state   <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (ARREADY) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (RVALID) begin
                        rd_data  <= RDATA;
                        rd_valid <= 1'b1;
                        if (RLAST) begin
                            rd_done  <= 1'b1;
                            rd_err   <= rd_err_acc | (RRESP != AXI_RESP_OKAY) | (beat_cnt != LAST_IDX);
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                        end else begin
                            // A non-last beat at or past the burst length already means a count mismatch.
                            if ((RRESP != AXI_RESP_OKAY) || (beat_cnt >= LAST_IDX)) rd_err_acc <= 1'b1;
                            if (beat_cnt != 5'h1f) beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign AWID        = '0;
    assign AWADDR      = addr_q;
    assign AWLEN       = AX_LEN;
    assign AWSIZE      = AX_SIZE;
    assign AWBURST     = AXI_BURST_INCR;
    assign AWVALID     = (state == ST_WR_ADDR);

    assign WDATA       = wr_data;
    assign WSTRB       = '1;
    assign WVALID      = (state == ST_WR_DATA);
    assign WLAST       = WVALID && (beat_cnt == LAST_IDX);
    assign wr_beat_ack = WVALID && WREADY;
    assign BREADY      = (state == ST_WR_RESP);

    assign ARID        = '0;
    assign ARADDR      = addr_q;
    assign ARLEN       = AX_LEN;
    assign ARSIZE      = AX_SIZE;
    assign ARBURST     = AXI_BURST_INCR;
    assign ARVALID     = (state == ST_RD_ADDR);
    assign RREADY      = (state == ST_RD_DATA);

endmodule

// File: rtl/axi_master_burst_ctrl.sv
// NUM_CH independent AXI4 burst masters behind one synchronised reset; AXI_WDATA_PARITY_EN adds per-byte WDATA parity.
// Latency and backpressure are per channel (see axi_master_burst_chan); channels never interact.
module axi_master_burst_ctrl
    import axi_master_pkg::*;
#(
    parameter int NUM_CH    = 16,
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 34,
    parameter int ID_W      = 6,
    parameter int BURST_LEN = 16
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_ARESET,

    input  logic [NUM_CH-1:0]                 wr_req,
    input  logic [NUM_CH-1:0]                 rd_req,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]     wr_addr,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]     rd_addr,
    input  logic [NUM_CH-1:0][DATA_W-1:0]     wr_data,
    output logic [NUM_CH-1:0]                 wr_beat_ack,
    output logic [NUM_CH-1:0][DATA_W-1:0]     rd_data,
    output logic [NUM_CH-1:0]                 rd_valid,
    output logic [NUM_CH-1:0]                 wr_done,
    output logic [NUM_CH-1:0]                 rd_done,
    output logic [NUM_CH-1:0]                 wr_err,
    output logic [NUM_CH-1:0]                 rd_err,

    output logic [NUM_CH-1:0][ID_W-1:0]       AWID,
    output logic [NUM_CH-1:0][ADDR_W-1:0]     AWADDR,
    output logic [NUM_CH-1:0][7:0]            AWLEN,
    output logic [NUM_CH-1:0][2:0]            AWSIZE,
    output logic [NUM_CH-1:0][1:0]            AWBURST,
    output logic [NUM_CH-1:0]                 AWVALID,
    input  logic [NUM_CH-1:0]                 AWREADY,
    output logic [NUM_CH-1:0][DATA_W-1:0]     WDATA,
    output logic [NUM_CH-1:0][DATA_W/8-1:0]   WSTRB,
    output logic [NUM_CH-1:0]                 WLAST,
    output logic [NUM_CH-1:0]                 WVALID,
    input  logic [NUM_CH-1:0]                 WREADY,
    input  logic [NUM_CH-1:0][1:0]            BRESP,
    input  logic [NUM_CH-1:0]                 BVALID,
    output logic [NUM_CH-1:0]                 BREADY,
    output logic [NUM_CH-1:0][ID_W-1:0]       ARID,
    output logic [NUM_CH-1:0][ADDR_W-1:0]     ARADDR,
    output logic [NUM_CH-1:0][7:0]            ARLEN,
    output logic [NUM_CH-1:0][2:0]            ARSIZE,
    output logic [NUM_CH-1:0][1:0]            ARBURST,
    output logic [NUM_CH-1:0]                 ARVALID,
    input  logic [NUM_CH-1:0]                 ARREADY,
    input  logic [NUM_CH-1:0][DATA_W-1:0]     RDATA,
    input  logic [NUM_CH-1:0][1:0]            RRESP,
    input  logic [NUM_CH-1:0]                 RLAST,
    input  logic [NUM_CH-1:0]                 RVALID,
`ifdef AXI_WDATA_PARITY_EN
    output logic [NUM_CH-1:0][DATA_W/8-1:0]   AXI_WDATA_PARITY,
`endif
    output logic [NUM_CH-1:0]                 RREADY
);

    // Assert immediately, release only after two clean edges so no channel sees a runt deassertion.
    logic [1:0] rst_pipe;
    logic       rst_int;

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) rst_pipe <= 2'b11;
        else            rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign rst_int = rst_pipe[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        axi_master_burst_chan #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .ID_W      (ID_W),
            .BURST_LEN (BURST_LEN)
        ) u_chan (
            .AXI_ACLK    (AXI_ACLK),
            .rst         (rst_int),
            .wr_req      (wr_req[c]),
            .rd_req      (rd_req[c]),
            .wr_addr     (wr_addr[c]),
            .rd_addr     (rd_addr[c]),
            .wr_data     (wr_data[c]),
            .wr_beat_ack (wr_beat_ack[c]),
            .rd_data     (rd_data[c]),
            .rd_valid    (rd_valid[c]),
            .wr_done     (wr_done[c]),
            .rd_done     (rd_done[c]),
            .wr_err      (wr_err[c]),
            .rd_err      (rd_err[c]),
            .AWID        (AWID[c]),
            .AWADDR      (AWADDR[c]),
            .AWLEN       (AWLEN[c]),
            .AWSIZE      (AWSIZE[c]),
            .AWBURST     (AWBURST[c]),
            .AWVALID     (AWVALID[c]),
            .AWREADY     (AWREADY[c]),
            .WDATA       (WDATA[c]),
            .WSTRB       (WSTRB[c]),
            .WLAST       (WLAST[c]),
            .WVALID      (WVALID[c]),
            .WREADY      (WREADY[c]),
            .BRESP       (BRESP[c]),
            .BVALID      (BVALID[c]),
            .BREADY      (BREADY[c]),
            .ARID        (ARID[c]),
            .ARADDR      (ARADDR[c]),
            .ARLEN       (ARLEN[c]),
            .ARSIZE      (ARSIZE[c]),
            .ARBURST     (ARBURST[c]),
            .ARVALID     (ARVALID[c]),
            .ARREADY     (ARREADY[c]),
            .RDATA       (RDATA[c]),
            .RRESP       (RRESP[c]),
            .RLAST       (RLAST[c]),
            .RVALID      (RVALID[c]),
            .RREADY      (RREADY[c])
        );
    end

`ifdef AXI_WDATA_PARITY_EN
    // Even parity per byte lane, straight off WDATA so it tracks the beat on the bus.
    always_comb begin
        AXI_WDATA_PARITY = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < DATA_W / 8; k++) begin
                AXI_WDATA_PARITY[c][k] = ^WDATA[c][8*k +: 8];
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_master_burst_ctrl.sv
// Directed bench for axi_master_burst_ctrl: writes, reads, arbitration, reset mid-burst, optional parity.
module tb_axi_master_burst_ctrl;

    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 34;
    localparam int ID_W      = 6;
    localparam int BURST_LEN = 16;
    localparam int NB        = DATA_W / 8;

    logic AXI_ACLK = 1'b0;
    logic AXI_ARESET;

    logic [NUM_CH-1:0]             wr_req, rd_req, wr_beat_ack, rd_valid, wr_done, rd_done, wr_err, rd_err;
    logic [NUM_CH-1:0][ADDR_W-1:0] wr_addr, rd_addr, AWADDR, ARADDR;
    logic [NUM_CH-1:0][DATA_W-1:0] wr_data, rd_data, WDATA, RDATA;
    logic [NUM_CH-1:0][ID_W-1:0]   AWID, ARID;
    logic [NUM_CH-1:0][7:0]        AWLEN, ARLEN;
    logic [NUM_CH-1:0][2:0]        AWSIZE, ARSIZE;
    logic [NUM_CH-1:0][1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic [NUM_CH-1:0][NB-1:0]     WSTRB;
    logic [NUM_CH-1:0]             AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [NUM_CH-1:0]             ARVALID, ARREADY, RLAST, RVALID, RREADY;
`ifdef AXI_WDATA_PARITY_EN
    logic [NUM_CH-1:0][NB-1:0]     AXI_WDATA_PARITY;
`endif

    int vectors    = 0;
    int miscompares = 0;

    axi_master_burst_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BURST_LEN(BURST_LEN)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
        .wr_req(wr_req), .rd_req(rd_req), .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .wr_beat_ack(wr_beat_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_done(wr_done), .rd_done(rd_done), .wr_err(wr_err), .rd_err(rd_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
`ifdef AXI_WDATA_PARITY_EN
        .AXI_WDATA_PARITY(AXI_WDATA_PARITY),
`endif
        .RREADY(RREADY)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    task automatic tick();
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wpat(input int ch, input int b);
        return {16'hD000 + 16'(ch), 16'h0000, 16'hBEEF, 16'(b)};
    endfunction

    function automatic logic [63:0] rpat(input int b);
        return {16'hF00D, 32'h1234_5678, 16'(b)};
    endfunction

    // Write burst on one channel; nstop < 16 leaves the channel mid-burst in the data phase.
    task automatic run_write(input int ch, input bit toggle, input logic [ADDR_W-1:0] addr,
                             input int nstop, input logic [1:0] bresp);
        int acc;
        int cyc;
        bit hs;
        wr_addr[ch] = addr;
        wr_data[ch] = wpat(ch, 0);
        AWREADY[ch] = 1'b1;
        wr_req[ch]  = 1'b1;
        cyc = 0;
        while (!AWVALID[ch] && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("aw_valid", 64'(AWVALID[ch]), 64'd1);
        chk("aw_addr", 64'(AWADDR[ch]), 64'(addr));
        chk("aw_len", 64'(AWLEN[ch]), 64'd15);
        chk("aw_size", 64'(AWSIZE[ch]), 64'd3);
        chk("aw_burst", 64'(AWBURST[ch]), 64'd1);
        chk("aw_id", 64'(AWID[ch]), 64'd0);
        chk("w_strb", 64'(WSTRB[ch]), 64'hFF);
        wr_req[ch] = 1'b0;
        tick();
        chk("aw_drop", 64'(AWVALID[ch]), 64'd0);
        acc = 0;
        cyc = 0;
        while (acc < nstop && cyc < 80) begin
            WREADY[ch] = toggle ? (cyc[0] == 1'b0) : 1'b1;
            #1;
            chk("w_valid", 64'(WVALID[ch]), 64'd1);
            chk("w_data", 64'(WDATA[ch]), wpat(ch, acc));
            chk("w_last", 64'(WLAST[ch]), 64'(acc == 15));
            chk("w_ack", 64'(wr_beat_ack[ch]), 64'(WREADY[ch]));
            hs = WREADY[ch];
            tick();
            cyc++;
            if (hs) begin
                acc++;
                wr_data[ch] = wpat(ch, acc);
            end
        end
        chk("w_beats", 64'(acc), 64'(nstop));
        if (nstop == 16) begin
            WREADY[ch] = 1'b0;
            chk("w_end", 64'(WVALID[ch]), 64'd0);
            chk("b_ready", 64'(BREADY[ch]), 64'd1);
            chk("wr_done_early", 64'(wr_done[ch]), 64'd0);
            BVALID[ch] = 1'b1;
            BRESP[ch]  = bresp;
            tick();
            chk("wr_done", 64'(wr_done[ch]), 64'd1);
            chk("wr_err", 64'(wr_err[ch]), 64'(bresp != 2'b00));
            chk("b_ready_off", 64'(BREADY[ch]), 64'd0);
            BVALID[ch] = 1'b0;
            BRESP[ch]  = 2'b00;
        end
    endtask

    // Read burst of n beats; errbeat is the 0-based beat carrying SLVERR, -1 for none.
    task automatic run_read(input int ch, input int n, input int errbeat, input logic [ADDR_W-1:0] addr);
        int cyc;
        logic exp_err;
        exp_err = (n != 16) || (errbeat >= 0 && errbeat < n);
        rd_addr[ch] = addr;
        ARREADY[ch] = 1'b1;
        rd_req[ch]  = 1'b1;
        cyc = 0;
        while (!ARVALID[ch] && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("ar_valid", 64'(ARVALID[ch]), 64'd1);
        chk("ar_addr", 64'(ARADDR[ch]), 64'(addr));
        chk("ar_len", 64'(ARLEN[ch]), 64'd15);
        chk("ar_burst", 64'(ARBURST[ch]), 64'd1);
        rd_req[ch] = 1'b0;
        tick();
        chk("r_ready", 64'(RREADY[ch]), 64'd1);
        for (int b = 0; b < n; b++) begin
            RVALID[ch] = 1'b1;
            RDATA[ch]  = rpat(b);
            RLAST[ch]  = (b == n - 1);
            RRESP[ch]  = (b == errbeat) ? 2'b10 : 2'b00;
            tick();
            chk("rd_valid", 64'(rd_valid[ch]), 64'd1);
            chk("rd_data", 64'(rd_data[ch]), rpat(b));
            chk("rd_done", 64'(rd_done[ch]), 64'(b == n - 1));
            if (b == n - 1) chk("rd_err", 64'(rd_err[ch]), 64'(exp_err));
        end
        RVALID[ch] = 1'b0;
        RLAST[ch]  = 1'b0;
        RRESP[ch]  = 2'b00;
        tick();
        chk("rd_valid_off", 64'(rd_valid[ch]), 64'd0);
        chk("rd_done_off", 64'(rd_done[ch]), 64'd0);
        chk("r_ready_off", 64'(RREADY[ch]), 64'd0);
    endtask

    initial begin
        AXI_ARESET = 1'b1;
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        AWREADY = '0; WREADY = '0; BRESP = '0; BVALID = '0;
        ARREADY = '0; RDATA = '0; RRESP = '0; RLAST = '0; RVALID = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_awvalid", 64'(AWVALID), 64'd0);
        chk("rst_wvalid", 64'(WVALID), 64'd0);
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_bready", 64'(BREADY), 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_done", 64'({wr_done, rd_done}), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);

        // Request raised at deassertion must not be taken on the first edge
        wr_addr[0] = 34'h1_0000_0000;
        AWREADY[0] = 1'b1;
        wr_req[0]  = 1'b1;
        AXI_ARESET = 1'b0;
        tick();
        chk("sync_edge1", 64'(AWVALID[0]), 64'd0);

        // Full write ch0, AWREADY/WREADY always high
        run_write(0, 1'b0, 34'h1_0000_0000, 16, 2'b00);
        tick();
        chk("wr_done_pulse", 64'(wr_done[0]), 64'd0);

        // WREADY toggling on ch5, then a write with SLVERR response
        run_write(5, 1'b1, 34'h0_0000_5000, 16, 2'b00);
        run_write(5, 1'b0, 34'h0_0000_5400, 16, 2'b10);

        // Stray B/R on an idle channel are ignored
        BVALID[3] = 1'b1; RVALID[3] = 1'b1; RLAST[3] = 1'b1;
        tick();
        tick();
        chk("stray_rd_valid", 64'(rd_valid[3]), 64'd0);
        chk("stray_done", 64'({wr_done[3], rd_done[3]}), 64'd0);
        BVALID[3] = 1'b0; RVALID[3] = 1'b0; RLAST[3] = 1'b0;

        // Reads on ch3: short burst, error mid-burst, clean burst
        run_read(3, 12, -1, 34'h2_0000_0300);
        run_read(3, 16, 3, 34'h2_0000_0400);
        run_read(3, 16, -1, 34'h2_0000_0800);

        // Simultaneous write and read request on ch7: write first
        rd_addr[7] = 34'h3_0000_0700;
        wr_addr[7] = 34'h3_0000_7000;
        AWREADY[7] = 1'b1;
        ARREADY[7] = 1'b1;
        rd_req[7]  = 1'b1;
        wr_req[7]  = 1'b1;
        tick();
        chk("both_aw", 64'(AWVALID[7]), 64'd1);
        chk("both_ar", 64'(ARVALID[7]), 64'd0);
        run_write(7, 1'b0, 34'h3_0000_7000, 16, 2'b00);
        chk("rd_after_wr", 64'(ARVALID[7]), 64'd0);
        run_read(7, 16, -1, 34'h3_0000_0700);

        // Reset in the middle of a write burst
        run_write(0, 1'b0, 34'h0_0000_0100, 8, 2'b00);
        WREADY[0] = 1'b1;
        BVALID[0] = 1'b1;
        #1;
        chk("mid_wvalid", 64'(WVALID[0]), 64'd1);
        AXI_ARESET = 1'b1;
        #1;
        chk("arst_wvalid", 64'(WVALID[0]), 64'd0);
        chk("arst_awvalid", 64'(AWVALID[0]), 64'd0);
        chk("arst_ack", 64'(wr_beat_ack[0]), 64'd0);
        chk("arst_bready", 64'(BREADY[0]), 64'd0);
        tick();
        AXI_ARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_done", 64'(wr_done[0]), 64'd0);
            chk("arst_idle", 64'({AWVALID[0], WVALID[0], BREADY[0]}), 64'd0);
        end
        BVALID[0] = 1'b0;
        WREADY[0] = 1'b0;
        run_write(0, 1'b0, 34'h0_0000_0200, 16, 2'b00);

`ifdef AXI_WDATA_PARITY_EN
        wr_data[1] = 64'h0000_0000_0000_0307;
        #1;
        chk("parity_b0", 64'(AXI_WDATA_PARITY[1][0]), 64'd1);
        chk("parity_b1", 64'(AXI_WDATA_PARITY[1][1]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
